fb_write_arbiter: RTL and testbench

Shares the single framebuffer write port among `NUM_REQ` pixel plotters and owns a built-in frame-clear sequencer. Plotters present address/pixel pairs over valid/ready handshakes. The block grants one write per cycle in round-robin order and drives a registered write port toward the framebuffer memory. A clear request sweeps every pixel address with a single colour and blocks all plotters until the sweep completes.

---
 rtl/interfaces.sv | 22 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/fb_write_arbiter.sv | 139 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/interfaces.sv
// Shared framebuffer types and geometry constants.
package interfaces;

    localparam int unsigned FB_WIDTH  = 640;
    localparam int unsigned FB_HEIGHT = 480;
    localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned FB_ADDR_W = $clog2(FB_PIXELS);
    localparam int unsigned PIXEL_W   = 32;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
        logic [7:0] alpha;
    } pixel_t;

    typedef enum logic {
        StIdle,
        StClear
    } fb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] request,
    input  logic         enable,
    output logic [N-1:0] grant
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] pointer_q, pointer_d;

    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant     = '0;
        pointer_d = pointer_q;
        sum       = '0;
        idx       = '0;
        if (enable) begin
            for (int i = 0; i < N; i++) begin
                sum = {1'b0, pointer_q} + (PTR_W + 1)'(i);
                if (sum >= (PTR_W + 1)'(N)) begin
                    sum = sum - (PTR_W + 1)'(N);
                end
                idx = sum[PTR_W-1:0];
                if (request[idx] && (grant == '0)) begin
                    grant[idx] = 1'b1;
                    pointer_d  = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer_q <= '0;
        end else begin
            pointer_q <= pointer_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter with a built-in full-frame clear sequencer.
module fb_write_arbiter
    import interfaces::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned HEIGHT  = FB_HEIGHT,
    parameter int unsigned WIDTH   = FB_WIDTH,
    localparam int unsigned ADDR_W = $clog2(HEIGHT * WIDTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
    input  logic [NUM_REQ*PIXEL_W-1:0] req_data,
    input  logic                       clear_start,
    input  logic [PIXEL_W-1:0]         clear_color,
    output logic                       clear_busy,
    input  logic                       fb_ready,
    output logic                       fb_write_enable,
    output logic [ADDR_W-1:0]          fb_address,
    output logic [PIXEL_W-1:0]         fb_data,
    output logic                       range_error
);

    localparam int unsigned       PIXELS     = HEIGHT * WIDTH;
    localparam logic [ADDR_W:0]   PIXELS_EXT = (ADDR_W + 1)'(PIXELS);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(PIXELS - 1);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clear_index_q, clear_index_d;
    pixel_t            clear_color_q, clear_color_d;
    logic              write_enable_d;
    logic [ADDR_W-1:0] address_d;
    pixel_t            data_d;
    logic              range_error_d;

    logic               slot_free;
    logic               arb_enable;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  sel_address;
    pixel_t             sel_data;
    logic               sel_in_range;

    assign slot_free  = !fb_write_enable || fb_ready;
    // Gated by reset so no handshake can complete while the block is held in reset.
    assign arb_enable = slot_free && (state_q == StIdle) && !reset;
    assign req_ready  = grant;
    assign clear_busy = (state_q == StClear);

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arbiter (
        .clock   (clock),
        .reset   (reset),
        .request (req_valid),
        .enable  (arb_enable),
        .grant   (grant)
    );

    always_comb begin
        sel_address = '0;
        sel_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_address = sel_address | req_address[i*ADDR_W +: ADDR_W];
                sel_data    = sel_data | pixel_t'(req_data[i*PIXEL_W +: PIXEL_W]);
            end
        end
    end

    assign sel_in_range = ({1'b0, sel_address} < PIXELS_EXT);

    always_comb begin
        state_d        = state_q;
        clear_index_d  = clear_index_q;
        clear_color_d  = clear_color_q;
        write_enable_d = fb_write_enable;
        address_d      = fb_address;
        data_d         = pixel_t'(fb_data);
        range_error_d  = 1'b0;
        if (slot_free) begin
            write_enable_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (|grant) begin
                    if (sel_in_range) begin
                        write_enable_d = 1'b1;
                        address_d      = sel_address;
                        data_d         = sel_data;
                    end else begin
                        range_error_d = 1'b1;
                    end
                end
                if (clear_start) begin
                    state_d       = StClear;
                    clear_color_d = pixel_t'(clear_color);
                    clear_index_d = '0;
                end
            end
            StClear: begin
                if (slot_free) begin
                    write_enable_d = 1'b1;
                    address_d      = clear_index_q;
                    data_d         = clear_color_q;
                    if (clear_index_q == LAST_INDEX) begin
                        state_d       = StIdle;
                        clear_index_d = '0;
                    end else begin
                        clear_index_d = clear_index_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            clear_index_q   <= '0;
            clear_color_q   <= '0;
            fb_write_enable <= 1'b0;
            fb_address      <= '0;
            fb_data         <= '0;
            range_error     <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_index_q   <= clear_index_d;
            clear_color_q   <= clear_color_d;
            fb_write_enable <= write_enable_d;
            fb_address      <= address_d;
            fb_data         <= data_d;
            range_error     <= range_error_d;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on a small 6x10 frame so full clear sweeps stay short.
module tb_fb_write_arbiter;
    import interfaces::*;

    localparam int unsigned NR = 4;
    localparam int unsigned H  = 6;
    localparam int unsigned W  = 10;
    localparam int unsigned P  = H * W;
    localparam int unsigned AW = $clog2(P);

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_address;
    logic [NR*32-1:0]  req_data;
    logic              clear_start;
    logic [31:0]       clear_color;
    logic              clear_busy;
    logic              fb_ready;
    logic              fb_write_enable;
    logic [AW-1:0]     fb_address;
    logic [31:0]       fb_data;
    logic              range_error;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] addr_tab [NR] = '{6'd5, 6'd15, 6'd25, 6'd35};
    logic [31:0]   data_tab [NR] = '{32'h10203040, 32'h11213141, 32'h01020304, 32'h13233343};

    typedef struct {
        logic [NR-1:0] valid;
        logic          fbr;
        logic          bad;
        logic [NR-1:0] ready;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          rerr;
    } vec_t;

    vec_t vecs [15];

    fb_write_arbiter #(
        .NUM_REQ (NR),
        .HEIGHT  (H),
        .WIDTH   (W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_address     (req_address),
        .req_data        (req_data),
        .clear_start     (clear_start),
        .clear_color     (clear_color),
        .clear_busy      (clear_busy),
        .fb_ready        (fb_ready),
        .fb_write_enable (fb_write_enable),
        .fb_address      (fb_address),
        .fb_data         (fb_data),
        .range_error     (range_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic bad);
        for (int i = 0; i < NR; i++) begin
            req_address[i*AW +: AW] = (bad && i == 1) ? 6'd60 : addr_tab[i];
            req_data[i*32 +: 32]    = data_tab[i];
        end
        req_valid = v;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // valid, fb_ready, bad, ready, we, addr, data, range_error
        vecs[0]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 6'd0,  32'h0,        1'b0};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 6'd25, 32'h01020304, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0, 6'd0,  32'h0,        1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 6'd35, 32'h13233343, 1'b0};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 6'd5,  32'h10203040, 1'b0};
        vecs[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 6'd15, 32'h11213141, 1'b0};
        vecs[6]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 6'd25, 32'h01020304, 1'b0};
        vecs[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 6'd35, 32'h13233343, 1'b0};
        vecs[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 6'd35, 32'h13233343, 1'b0};
        vecs[9]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 6'd35, 32'h13233343, 1'b0};
        vecs[10] = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 6'd35, 32'h13233343, 1'b0};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 6'd5,  32'h10203040, 1'b0};
        vecs[12] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0, 6'd0,  32'h0,        1'b0};
        vecs[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 6'd0,  32'h0,        1'b1};
        vecs[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 6'd0,  32'h0,        1'b0};

        reset       = 1'b1;
        clear_start = 1'b0;
        clear_color = '0;
        fb_ready    = 1'b1;
        drive('0, 1'b0);
        tick();
        chk("reset we", 32'(fb_write_enable), 32'd0);
        chk("reset addr", 32'(fb_address), 32'd0);
        chk("reset data", fb_data, 32'd0);
        chk("reset busy", 32'(clear_busy), 32'd0);
        chk("reset rerr", 32'(range_error), 32'd0);
        tick();
        reset = 1'b0;

        for (int k = 0; k < 15; k++) begin
            drive(vecs[k].valid, vecs[k].bad);
            fb_ready = vecs[k].fbr;
            #1;
            chk($sformatf("v%0d ready", k), 32'(req_ready), 32'(vecs[k].ready));
            chk($sformatf("v%0d we", k), 32'(fb_write_enable), 32'(vecs[k].we));
            chk($sformatf("v%0d rerr", k), 32'(range_error), 32'(vecs[k].rerr));
            chk($sformatf("v%0d busy", k), 32'(clear_busy), 32'd0);
            if (vecs[k].we) begin
                chk($sformatf("v%0d addr", k), 32'(fb_address), 32'(vecs[k].addr));
                chk($sformatf("v%0d data", k), fb_data, vecs[k].data);
            end
            tick();
        end

        // Clear with a same-cycle handshake; pointer sits at 2 after the table.
        drive(4'b1111, 1'b0);
        fb_ready    = 1'b1;
        clear_color = 32'h000000FF;
        clear_start = 1'b1;
        #1;
        chk("clear start grant", 32'(req_ready), 32'b0100);
        tick();
        clear_start = 1'b0;
        clear_color = 32'hDEADBEEF;
        chk("clear t+1 busy", 32'(clear_busy), 32'd1);
        chk("clear t+1 ready", 32'(req_ready), 32'd0);
        chk("clear t+1 we", 32'(fb_write_enable), 32'd1);
        chk("clear t+1 addr", 32'(fb_address), 32'd25);
        chk("clear t+1 data", fb_data, 32'h01020304);
        for (int k = 0; k < P; k++) begin
            tick();
            clear_start = (k == 30);
            clear_color = (k == 30) ? 32'h12345678 : 32'hDEADBEEF;
            #1;
            chk($sformatf("clear %0d we", k), 32'(fb_write_enable), 32'd1);
            chk($sformatf("clear %0d addr", k), 32'(fb_address), 32'(k));
            chk($sformatf("clear %0d data", k), fb_data, 32'h000000FF);
            if (k < P - 1) begin
                chk($sformatf("clear %0d busy", k), 32'(clear_busy), 32'd1);
                chk($sformatf("clear %0d ready", k), 32'(req_ready), 32'd0);
            end else begin
                chk("clear last busy", 32'(clear_busy), 32'd0);
                chk("clear last ready", 32'(req_ready), 32'b1000);
            end
        end
        clear_start = 1'b0;
        tick();
        drive('0, 1'b0);
        #1;
        chk("post clear we", 32'(fb_write_enable), 32'd1);
        chk("post clear addr", 32'(fb_address), 32'd35);
        chk("post clear data", fb_data, 32'h13233343);
        tick();
        tick();

        // Reset in the middle of a sweep with the slot occupied.
        clear_color = 32'h000000FF;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (21) tick();
        chk("mid clear addr", 32'(fb_address), 32'd20);
        chk("mid clear we", 32'(fb_write_enable), 32'd1);
        drive(4'b1111, 1'b0);
        reset = 1'b1;
        #1;
        chk("async reset we", 32'(fb_write_enable), 32'd0);
        chk("async reset addr", 32'(fb_address), 32'd0);
        chk("async reset data", fb_data, 32'd0);
        chk("async reset busy", 32'(clear_busy), 32'd0);
        chk("async reset ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("after reset ready", 32'(req_ready), 32'b0001);
        tick();
        drive('0, 1'b0);
        #1;
        chk("after reset we", 32'(fb_write_enable), 32'd1);
        chk("after reset addr", 32'(fb_address), 32'd5);
        chk("after reset busy", 32'(clear_busy), 32'd0);
        tick();
        chk("no resume we", 32'(fb_write_enable), 32'd0);
        chk("no resume busy", 32'(clear_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
